booth_wallace_mult_12x12: RTL and testbench

Signed 12x12 two's-complement multiplier producing a full 24-bit product. It uses radix-4 Booth partial-product generation, a carry-save (Wallace) reduction tree and a final 24-bit carry-ripple adder. The block is fully pipelined, accepts one operand pair per clock with no back-pressure, and sits in the arithmetic datapath as the reusable Booth multiplier core.

---
 rtl/booth_wallace_mult_12x12_if.sv | 11 +
 rtl/booth_wallace_mult_12x12.sv | 80 ++++++++
 tb/tb_booth_wallace_mult_12x12.sv | 136 +++++++++++++
 3 files changed

// File: rtl/booth_wallace_mult_12x12_if.sv
// rtl/booth_wallace_mult_12x12_if.sv - operand/product bundle for the 12x12 Booth multiplier
interface booth_wallace_mult_12x12_if;
  logic        in_valid;
  logic [11:0] x;
  logic [11:0] y;
  logic [23:0] p;
  logic        out_valid;

  modport master (output in_valid, x, y, input p, out_valid);
  modport slave  (input in_valid, x, y, output p, out_valid);
endinterface

// File: rtl/booth_wallace_mult_12x12.sv
// rtl/booth_wallace_mult_12x12.sv - two-stage signed 12x12 radix-4 Booth / Wallace multiplier
module booth_wallace_mult_12x12 (
  input logic                     clk,
  input logic                     rst,
  booth_wallace_mult_12x12_if.slave bus
);

  logic [11:0] x_r;
  logic [11:0] y_r;
  logic        v_r;
  logic [12:0] y_ext;
  logic [13:0] pp  [6];
  logic [23:0] spp [6];
  logic [47:0] l1a, l1b, l2, l3;
  logic [23:0] prod;

  // One Booth digit times x as an exact 14-bit two's-complement value.
  function automatic logic [13:0] gen_pp(input logic [2:0] bits, input logic [11:0] xv);
    logic [13:0] x1;
    logic [13:0] x2;
    x1 = {{2{xv[11]}}, xv};
    x2 = {x1[12:0], 1'b0};
    case (bits)
      3'b001, 3'b010: gen_pp = x1;
      3'b011:         gen_pp = x2;
      3'b100:         gen_pp = ~x2 + 14'd1;
      3'b101, 3'b110: gen_pp = ~x1 + 14'd1;
      default:        gen_pp = '0;
    endcase
  endfunction

  // Returns {sum, carry}; carry is already shifted up with bit 0 cleared.
  function automatic logic [47:0] csa(input logic [23:0] a, input logic [23:0] b,
                                      input logic [23:0] c);
    logic [23:0] s;
    logic [23:0] co;
    s  = a ^ b ^ c;
    co = {(a[22:0] & b[22:0]) | (a[22:0] & c[22:0]) | (b[22:0] & c[22:0]), 1'b0};
    csa = {s, co};
  endfunction

  function automatic logic [23:0] ripple(input logic [23:0] a, input logic [23:0] b);
    logic c;
    c = 1'b0;
    for (int i = 0; i < 24; i++) begin
      ripple[i] = a[i] ^ b[i] ^ c;
      c         = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
  endfunction

  always_comb begin
    y_ext = {y_r, 1'b0};
    for (int i = 0; i < 6; i++) begin
      pp[i]  = gen_pp(y_ext[2*i +: 3], x_r);
      spp[i] = {{10{pp[i][13]}}, pp[i]} << (2 * i);
    end
    l1a  = csa(spp[0], spp[1], spp[2]);
    l1b  = csa(spp[3], spp[4], spp[5]);
    l2   = csa(l1a[47:24], l1a[23:0], l1b[47:24]);
    l3   = csa(l2[47:24], l2[23:0], l1b[23:0]);
    prod = ripple(l3[47:24], l3[23:0]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_r           <= '0;
      y_r           <= '0;
      v_r           <= 1'b0;
      bus.p         <= '0;
      bus.out_valid <= 1'b0;
    end else begin
      x_r           <= bus.x;
      y_r           <= bus.y;
      v_r           <= bus.in_valid;
      bus.p         <= prod;
      bus.out_valid <= v_r;
    end
  end

endmodule

// File: tb/tb_booth_wallace_mult_12x12.sv
// tb/tb_booth_wallace_mult_12x12.sv - directed and random checks of the 12x12 Booth multiplier
module tb_booth_wallace_mult_12x12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  logic        m1_v = 1'b0;
  logic [23:0] m1_p = '0;

  booth_wallace_mult_12x12_if bus ();

  booth_wallace_mult_12x12 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; drives one operand pair and checks what leaves the pipe after the edge.
  task automatic step(input logic v, input logic [11:0] a, input logic [11:0] b,
                      input logic [23:0] e, input string tag);
    logic        ev;
    logic [23:0] ep;
    bus.in_valid = v;
    bus.x        = a;
    bus.y        = b;
    @(posedge clk);
    #1;
    ev   = m1_v;
    ep   = m1_p;
    m1_v = v;
    m1_p = e;
    check({tag, "_ov"}, {23'd0, bus.out_valid}, {23'd0, ev});
    if (ev) check({tag, "_p"}, bus.p, ep);
    @(negedge clk);
  endtask

  function automatic logic [23:0] ref_mul(input logic [11:0] a, input logic [11:0] b);
    int ia;
    int ib;
    int r;
    ia = int'($signed(a));
    ib = int'($signed(b));
    r  = ia * ib;
    return r[23:0];
  endfunction

  initial begin
    logic [11:0] ra;
    logic [11:0] rb;
    logic        rv;

    bus.in_valid = 1'b0;
    bus.x        = '0;
    bus.y        = '0;
    #2;
    check("reset_p", bus.p, 24'd0);
    check("reset_ov", {23'd0, bus.out_valid}, 24'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // All-ones magnitudes back-to-back
    step(1'b1, 12'h1FF, 12'h1FF, 24'd261121,  "ones9");
    step(1'b1, 12'h3FF, 12'h3FF, 24'd1046529, "ones10");
    step(1'b1, 12'h7FF, 12'h7FF, 24'd4190209, "ones11");
    step(1'b1, 12'hFFF, 12'hFFF, 24'd1,       "ones12");

    // Extremes
    step(1'b1, 12'h800, 12'h800, 24'h400000, "nmax_nmax");
    step(1'b1, 12'h800, 12'h7FF, 24'hC00800, "nmax_pmax");
    step(1'b1, 12'h7FF, 12'h7FF, 24'h3FF001, "pmax_pmax");
    step(1'b1, 12'h000, 12'h800, 24'h000000, "zero_nmax");

    // Booth digit coverage
    step(1'b1, 12'd5, 12'h001, 24'd5,       "booth_1");
    step(1'b1, 12'd5, 12'h002, 24'd10,      "booth_2");
    step(1'b1, 12'd5, 12'h003, 24'd15,      "booth_3");
    step(1'b1, 12'd5, 12'h004, 24'd20,      "booth_4");
    step(1'b1, 12'd5, 12'hAAA, 24'hFFE552,  "booth_aaa");
    step(1'b1, 12'd5, 12'h555, 24'h001AA9,  "booth_555");

    // Bubbles with changing operands
    step(1'b1, 12'd3,    12'd7,    24'd21,      "bub0");
    step(1'b0, 12'd100,  12'd100,  24'd10000,   "bub1");
    step(1'b1, 12'hFFE,  12'd9,    24'hFFFFEE,  "bub2");
    step(1'b0, 12'd11,   12'hFFD,  24'hFFFFDF,  "bub3");
    step(1'b1, 12'd1000, 12'hC18,  24'hF0BDC0,  "bub4");
    step(1'b0, 12'd0,    12'd0,    24'd0,       "bub5");
    step(1'b0, 12'd0,    12'd0,    24'd0,       "bub6");

    // Reset mid-cycle with two products in flight
    step(1'b1, 12'd12, 12'd12, 24'd144, "pre_rst0");
    step(1'b1, 12'd13, 12'd13, 24'd169, "pre_rst1");
    bus.in_valid = 1'b1;
    bus.x        = 12'd14;
    bus.y        = 12'd14;
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_p", bus.p, 24'd0);
    check("rst_async_ov", {23'd0, bus.out_valid}, 24'd0);
    @(negedge clk);
    rst  = 1'b0;
    m1_v = 1'b0;
    step(1'b0, 12'd0, 12'd0, 24'd0, "post_rst0");
    step(1'b0, 12'd0, 12'd0, 24'd0, "post_rst1");
    step(1'b1, 12'h801, 12'h003, 24'hFFE803, "post_rst2");
    step(1'b0, 12'd0, 12'd0, 24'd0, "post_rst3");

    // Random signed pairs against the integer reference
    for (int i = 0; i < 10000; i++) begin
      ra = 12'($urandom);
      rb = 12'($urandom);
      rv = ($urandom_range(0, 7) != 0);
      step(rv, ra, rb, ref_mul(ra, rb), "rand");
    end
    step(1'b0, 12'd0, 12'd0, 24'd0, "drain0");
    step(1'b0, 12'd0, 12'd0, 24'd0, "drain1");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
